high_score_board: RTL

HIGH_SCORE_BOARD -- requirements
Module: high_score_board

---
 rtl/high_score_board_if.sv | 30 +++
 rtl/high_score_board.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/high_score_board_if.sv
// Bus bundle for the reaction-time leaderboard: submit/key inputs and display outputs.
// The master side drives en/key/score; the board (slave) drives the display signals.
interface high_score_board_if #(
    parameter int DIGITS = 3,
    parameter int DEPTH  = 4
);
    localparam int SW = 4 * DIGITS;
    localparam int RW = $clog2(DEPTH);
    localparam int CW = RW + 1;

    logic          en;
    logic [1:0]    key;
    logic [SW-1:0] score;
    logic [SW-1:0] disp_bcd;
    logic [RW-1:0] disp_rank;
    logic          disp_valid;
    logic          new_best;
    logic [CW-1:0] ins_rank;
    logic [3:0]    out_state;

    modport master (
        output en, key, score,
        input  disp_bcd, disp_rank, disp_valid, new_best, ins_rank, out_state
    );

    modport slave (
        input  en, key, score,
        output disp_bcd, disp_rank, disp_valid, new_best, ins_rank, out_state
    );
endinterface

// File: rtl/high_score_board.sv
// Sorted BCD reaction-time leaderboard: inserts submitted scores, then shows the
// board for HOLD_MS milliseconds while en stays high.
module high_score_board #(
    parameter int DIGITS  = 3,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 50000,
    parameter int HOLD_MS = 3000
) (
    input logic              clk,
    input logic              rst_n,
    high_score_board_if.slave bus
);
    localparam int SW = 4 * DIGITS;
    localparam int RW = $clog2(DEPTH);
    localparam int CW = RW + 1;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;

    typedef enum logic [1:0] {IDLE, INSERT, SHOW, DONE} state_t;

    state_t        state, state_nx;
    logic          en_p0, en_p1, en_p2;
    logic [1:0]    key_p0, key_p1, key_p2;
    logic [SW-1:0] tbl [DEPTH];
    logic [CW-1:0] count;
    logic [RW-1:0] disp_rank;
    logic [CW-1:0] ins_rank;
    logic          new_best;
    logic          clr_pend;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold;

    logic          en_rise;
    logic [1:0]    key_fall;
    logic          tick;
    logic          clr_now;
    logic [CW-1:0] ins_pos;
    logic          ins_ok;

    // Zero and any digit above 9 are not valid reaction times.
    function automatic logic bcd_ok(input logic [SW-1:0] v);
        logic ok;
        ok = (v != '0);
        for (int d = 0; d < DIGITS; d++)
            if (v[4*d +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    assign en_rise  = en_p1 & ~en_p2;
    assign key_fall = key_p2 & ~key_p1;
    assign tick     = (state == SHOW) && (presc == PW'(CLK_DIV - 1));
    assign clr_now  = (key_fall[1] && state != INSERT) || clr_pend;

    // Valid BCD orders like plain unsigned binary, so a direct compare is enough.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && tbl[i] <= bus.score) ins_pos = ins_pos + CW'(1);
    end

    assign ins_ok = bcd_ok(bus.score) && (ins_pos != CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en_rise) state_nx = INSERT;
            INSERT:  state_nx = SHOW;
            SHOW: begin
                if (!en_p1)
                    state_nx = IDLE;
                else if (hold == '0 || (tick && hold == HW'(1)))
                    state_nx = DONE;
            end
            DONE:    if (!en_p1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Input synchroniser stages p0/p1; p2 holds the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_p0  <= 1'b0;
            en_p1  <= 1'b0;
            en_p2  <= 1'b0;
            key_p0 <= 2'b11;
            key_p1 <= 2'b11;
            key_p2 <= 2'b11;
        end else begin
            en_p0  <= bus.en;
            en_p1  <= en_p0;
            en_p2  <= en_p1;
            key_p0 <= bus.key;
            key_p1 <= key_p0;
            key_p2 <= key_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
            count     <= '0;
            disp_rank <= '0;
            ins_rank  <= CW'(DEPTH);
            new_best  <= 1'b0;
            clr_pend  <= 1'b0;
            presc     <= '0;
            hold      <= '0;
        end else begin
            new_best <= 1'b0;
            clr_pend <= key_fall[1] && (state == INSERT);

            if (state == INSERT) begin
                ins_rank <= ins_ok ? ins_pos : CW'(DEPTH);
                new_best <= ins_ok && (ins_pos == '0);
                if (ins_ok) begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        if (CW'(i) > ins_pos)       tbl[i] <= tbl[i-1];
                        else if (CW'(i) == ins_pos) tbl[i] <= bus.score;
                    end
                    if (ins_pos == '0) tbl[0] <= bus.score;
                    if (count != CW'(DEPTH)) count <= count + CW'(1);
                end
            end

            if (state == INSERT) begin
                presc <= '0;
                hold  <= HW'(HOLD_MS);
            end else if (tick) begin
                presc <= '0;
                if (hold != '0) hold <= hold - HW'(1);
            end else if (state == SHOW) begin
                presc <= presc + PW'(1);
            end

            // Clear beats a simultaneous next-rank press; a clear seen in INSERT lands one cycle later.
            if (clr_now) begin
                count     <= '0;
                disp_rank <= '0;
            end else if (state == INSERT) begin
                disp_rank <= '0;
            end else if (key_fall[0]) begin
                if (count == '0 || ({1'b0, disp_rank} + CW'(1)) >= count)
                    disp_rank <= '0;
                else
                    disp_rank <= disp_rank + RW'(1);
            end
        end
    end

    assign bus.disp_rank  = disp_rank;
    assign bus.disp_valid = ({1'b0, disp_rank} < count);
    assign bus.disp_bcd   = bus.disp_valid ? tbl[disp_rank] : '0;
    assign bus.new_best   = new_best;
    assign bus.ins_rank   = ins_rank;
    assign bus.out_state  = (state == DONE) ? 4'd0 : 4'd3;
endmodule
